// File: rtl/cursor_nav_ctrl.sv
// Grid cursor navigator: five active-low buttons are synchronised and debounced, and
// direction buttons auto-repeat. The cursor moves on a COLS x ROWS grid, clamping or wrapping at the edges.

module cursor_nav_btn #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_RATE     = 200,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX + 1);

  logic [1:0]    sync;
  logic [DW-1:0] dcnt;
  logic          deb, deb_d, press, rep, rep_phase;
  logic [HW-1:0] hcnt, hlim;

  assign hlim = rep_phase ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY);
  assign evt  = press | rep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      dcnt      <= '0;
      deb       <= 1'b1;
      deb_d     <= 1'b1;
      press     <= 1'b0;
      rep       <= 1'b0;
      rep_phase <= 1'b0;
      hcnt      <= '0;
    end else begin
      sync  <= {sync[0], raw};
      deb_d <= deb;
      press <= deb_d & ~deb;
      if (sync[1] == deb) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb  <= sync[1];
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
      // Hold counter is armed on the same edge the press event registers.
      if (!REPEAT_EN || deb) begin
        hcnt      <= '0;
        rep_phase <= 1'b0;
        rep       <= 1'b0;
      end else if (deb_d) begin
        hcnt      <= HW'(1);
        rep_phase <= 1'b0;
        rep       <= 1'b0;
      end else if (hcnt == hlim) begin
        hcnt      <= HW'(1);
        rep_phase <= 1'b1;
        rep       <= 1'b1;
      end else begin
        hcnt <= hcnt + HW'(1);
        rep  <= 1'b0;
      end
    end
  end
endmodule

module cursor_nav_ctrl #(
  parameter int COLS            = 3,
  parameter int ROWS            = 4,
  parameter int X_W             = 4,
  parameter int Y_W             = 4,
  parameter int INIT_X          = 1,
  parameter int INIT_Y          = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_RATE     = 200,
  parameter int WRAP            = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_sel,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y,
  output logic           move_pulse,
  output logic           sel_pulse
);
  localparam logic [X_W-1:0] X_MAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(ROWS - 1);

  // Bit order: {sel, up, down, left, right}
  logic [4:0]     raw, evt;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;

  assign raw = {btn_sel, btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    cursor_nav_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (i != 4)
    ) u_btn (
      .clk(clk),
      .rst(rst),
      .raw(raw[i]),
      .evt(evt[i])
    );
  end

  always_comb begin
    nx = cursor_x;
    ny = cursor_y;
    if (evt[3] && !evt[2]) begin
      if (cursor_y == '0) ny = (WRAP != 0) ? Y_MAX : cursor_y;
      else                ny = cursor_y - Y_W'(1);
    end else if (evt[2] && !evt[3]) begin
      if (cursor_y == Y_MAX) ny = (WRAP != 0) ? '0 : cursor_y;
      else                   ny = cursor_y + Y_W'(1);
    end
    if (evt[1] && !evt[0]) begin
      if (cursor_x == '0) nx = (WRAP != 0) ? X_MAX : cursor_x;
      else                nx = cursor_x - X_W'(1);
    end else if (evt[0] && !evt[1]) begin
      if (cursor_x == X_MAX) nx = (WRAP != 0) ? '0 : cursor_x;
      else                   nx = cursor_x + X_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_x   <= X_W'(INIT_X);
      cursor_y   <= Y_W'(INIT_Y);
      move_pulse <= 1'b0;
      sel_pulse  <= 1'b0;
    end else begin
      cursor_x   <= nx;
      cursor_y   <= ny;
      move_pulse <= (nx != cursor_x) || (ny != cursor_y);
      sel_pulse  <= evt[4];
    end
  end
endmodule

// File: tb/tb_cursor_nav_ctrl.sv
// Scoreboard bench: a clamp instance and a wrap instance share the buttons; a transaction
// model predicts every strobe (edge, cursor, kind) and the monitor pops and compares it.
module tb_cursor_nav_ctrl;
  localparam int D = 4, DLY = 20, RATE = 5, COLS = 3, ROWS = 4, XW = 4, YW = 4;
  localparam int NEVER = 1 << 30;

  typedef struct { int cyc; int x; int y; int kind; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1, btn_sel = 1'b1;
  logic [XW-1:0] cx0, cx1;
  logic [YW-1:0] cy0, cy1;
  logic mp0, mp1, sp0, sp1;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   mx[2], my[2];
  ev_t  q0[$], q1[$];

  cursor_nav_ctrl #(.COLS(COLS), .ROWS(ROWS), .X_W(XW), .Y_W(YW), .INIT_X(1), .INIT_Y(1),
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .WRAP(0)) u_clamp (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .cursor_x(cx0), .cursor_y(cy0),
    .move_pulse(mp0), .sel_pulse(sp0));

  cursor_nav_ctrl #(.COLS(COLS), .ROWS(ROWS), .X_W(XW), .Y_W(YW), .INIT_X(1), .INIT_Y(1),
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .cursor_x(cx1), .cursor_y(cy1),
    .move_pulse(mp1), .sel_pulse(sp1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int i, input ev_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Model: one press/repeat event for button mask m lands on edge t.
  task automatic apply(input int t, input logic [4:0] m);
    int  nx, ny, kind;
    ev_t e;
    for (int i = 0; i < 2; i++) begin
      nx = mx[i];
      ny = my[i];
      if (m[3] && !m[2])      ny = (my[i] == 0) ? ((i == 1) ? ROWS - 1 : 0) : my[i] - 1;
      else if (m[2] && !m[3]) ny = (my[i] == ROWS - 1) ? ((i == 1) ? 0 : ROWS - 1) : my[i] + 1;
      if (m[1] && !m[0])      nx = (mx[i] == 0) ? ((i == 1) ? COLS - 1 : 0) : mx[i] - 1;
      else if (m[0] && !m[1]) nx = (mx[i] == COLS - 1) ? ((i == 1) ? 0 : COLS - 1) : mx[i] + 1;
      kind = 0;
      if (nx != mx[i] || ny != my[i]) kind = kind | 1;
      if (m[4]) kind = kind | 2;
      if (kind != 0) begin
        e.cyc = t; e.x = nx; e.y = ny; e.kind = kind;
        push(i, e);
      end
      mx[i] = nx;
      my[i] = ny;
    end
  endtask

  // Raw low sampled on edges c0..c0+n-1; events on or after edge 'cutoff' are lost to reset.
  task automatic expect_btn(input logic [4:0] m, input int c0, input int n, input int cutoff);
    if (n < D) return;
    if (c0 + D + 3 < cutoff) apply(c0 + D + 3, m);
    if (m[3:0] != 4'b0)
      for (int r = c0 + D + 2 + DLY; r <= c0 + n + D + 1; r += RATE)
        if (r + 1 < cutoff) apply(r + 1, {1'b0, m[3:0]});
  endtask

  task automatic drive(input logic [4:0] m);
    btn_sel = ~m[4]; btn_up = ~m[3]; btn_down = ~m[2]; btn_left = ~m[1]; btn_right = ~m[0];
  endtask

  task automatic mon(input int i, input logic m, input logic s, input int x, input int y);
    ev_t e;
    if (m | s) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        chk($sformatf("spurious_pulse%0d", i), {30'b0, s, m}, 0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("edge%0d", i), cyc, e.cyc);
        chk($sformatf("x%0d", i), x, e.x);
        chk($sformatf("y%0d", i), y, e.y);
        chk($sformatf("kind%0d", i), {30'b0, s, m}, e.kind);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, mp0, sp0, int'(cx0), int'(cy0));
      mon(1, mp1, sp1, int'(cx1), int'(cy1));
    end
  end

  task automatic reset_checks();
    q0.delete(); q1.delete();
    mx = '{1, 1}; my = '{1, 1};
    chk("rst_x0", cx0, 1); chk("rst_y0", cy0, 1); chk("rst_mp0", mp0, 0); chk("rst_sp0", sp0, 0);
    chk("rst_x1", cx1, 1); chk("rst_y1", cy1, 1); chk("rst_mp1", mp1, 0); chk("rst_sp1", sp1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold(input logic [4:0] m, input int n);
    int c0;
    @(negedge clk);
    c0 = cyc + 1;
    expect_btn(m, c0, n, NEVER);
    drive(m);
    repeat (n) @(negedge clk);
    drive(5'b0);
    repeat (D + 10) @(negedge clk);
    chk("drained0", q0.size(), 0);
    chk("drained1", q1.size(), 0);
  endtask

  localparam logic [4:0] SEL = 5'b10000, UP = 5'b01000, DN = 5'b00100, LT = 5'b00010, RT = 5'b00001;

  initial begin
    int c0;
    do_reset();
    // Glitch shorter than debounce, then a clean press
    hold(RT, 3);
    chk("t1_glitch_x", cx0, 1);
    hold(RT, 10);
    chk("t1_press_x", cx0, 2);
    // Edges: clamp vs wrap
    do_reset();
    hold(RT, 8); hold(DN, 8); hold(DN, 8);
    chk("t2_pre_x1", cx1, 2); chk("t2_pre_y1", cy1, 3);
    hold(RT, 8); hold(DN, 8);
    chk("t2_clamp_x", cx0, 2); chk("t2_clamp_y", cy0, 3);
    chk("t2_wrap_x", cx1, 0);  chk("t2_wrap_y", cy1, 0);
    // Auto-repeat
    do_reset();
    hold(UP, 8);
    hold(DN, 40);
    chk("t3_x", cx0, 1); chk("t3_y", cy0, 3);
    // Opposing and diagonal
    do_reset();
    hold(UP | DN, 8);
    chk("t4_cancel_y", cy0, 1);
    hold(UP | RT, 8);
    chk("t4_diag_x", cx0, 2); chk("t4_diag_y", cy0, 0);
    // Select: single strobe, no repeat
    hold(SEL, 100);
    chk("t5_x", cx0, 2); chk("t5_y", cy0, 0);
    // Reset in the middle of a repeat, button held through release
    hold(LT, 8); hold(LT, 8); hold(DN, 8); hold(DN, 8); hold(DN, 8);
    chk("t6_pre_x", cx0, 0); chk("t6_pre_y", cy0, 3);
    @(negedge clk);
    c0 = cyc + 1;
    expect_btn(DN, c0, NEVER / 2, c0 + 29);
    drive(DN);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = cyc + 1;
    expect_btn(DN, c0, 12, NEVER);
    repeat (12) @(negedge clk);
    drive(5'b0);
    repeat (D + 10) @(negedge clk);
    chk("t6_drained0", q0.size(), 0);
    chk("t6_drained1", q1.size(), 0);
    chk("t6_x", cx0, 1); chk("t6_y", cy0, 2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
